// File: rtl/flag_hazard_ctrl.sv
// Status register (N,Z,C,V), ID condition evaluation and flag interlock.
// Tracks in-flight flag writers between ID and EX; stalls or forwards.
module flag_hazard_ctrl #(
   parameter int DEPTH   = 1,
   parameter bit FORWARD = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       freeze,
   input  logic       flush,
   input  logic       id_valid,
   input  logic [3:0] id_cond,
   input  logic       id_s,
   input  logic       ex_valid,
   input  logic       ex_s,
   input  logic [3:0] ex_flags,
   output logic [3:0] flags,
   output logic       cond_pass,
   output logic       cond_stall,
   output logic [2:0] pend_cnt,
   output logic       seq_err
);

   // all slots younger than the EX slot
   localparam logic [DEPTH-1:0] YMASK = DEPTH'((1 << (DEPTH-1)) - 1);

   logic [DEPTH-1:0] pend;
   logic             ex_wr;
   logic             ex_claim;
   logic [3:0]       eff;
   logic             n, z, c, v;
   logic             needs_flags;
   logic             hazard;
   logic             issue_s;

   assign ex_claim    = ex_valid & ex_s;
   assign ex_wr       = ex_claim & ~freeze;
   assign eff         = (FORWARD && ex_wr) ? ex_flags : flags;
   assign {n, z, c, v} = eff;
   assign needs_flags = id_valid & (id_cond < 4'd14);
   assign hazard      = (|(pend & YMASK)) |
                        (pend[DEPTH-1] & ~(FORWARD & ex_wr));
   assign cond_stall  = needs_flags & hazard & ~flush;
   assign issue_s     = id_valid & id_s & cond_pass & ~cond_stall &
                        ~freeze & ~flush;

   // condition-code decode on the effective flags
   always_comb begin
      cond_pass = 1'b0;
      case (id_cond)
         4'd0:    cond_pass = z;
         4'd1:    cond_pass = ~z;
         4'd2:    cond_pass = c;
         4'd3:    cond_pass = ~c;
         4'd4:    cond_pass = n;
         4'd5:    cond_pass = ~n;
         4'd6:    cond_pass = v;
         4'd7:    cond_pass = ~v;
         4'd8:    cond_pass = c & ~z;
         4'd9:    cond_pass = ~c | z;
         4'd10:   cond_pass = (n == v);
         4'd11:   cond_pass = (n != v);
         4'd12:   cond_pass = ~z & (n == v);
         4'd13:   cond_pass = z | (n != v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // population count of in-flight flag writers
   always_comb begin
      pend_cnt = 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_cnt = pend_cnt + 3'(pend[i]);
      end
   end

   // architectural status register, written by EX (flush does not gate it)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags <= 4'b0000;
      end else if (ex_wr) begin
         flags <= ex_flags;
      end
   end

   // pending shift register: freeze holds, flush squashes younger slots
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
      end else if (!freeze) begin
         if (flush) begin
            pend <= '0;
         end else begin
            pend <= (pend << 1) | DEPTH'(issue_s);
         end
      end
   end

   // sticky mismatch between EX flag writer and the EX slot of pend
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq_err <= 1'b0;
      end else if (!freeze && (ex_claim != pend[DEPTH-1])) begin
         seq_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Bench for flag_hazard_ctrl: four configurations (DEPTH 1/3, FORWARD 0/1)
// checked every cycle against a behavioural model plus directed literals.
module tb_flag_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       freeze_i   [4];
   logic       flush_i    [4];
   logic       id_valid_i [4];
   logic [3:0] id_cond_i  [4];
   logic       id_s_i     [4];
   logic       ex_valid_i [4];
   logic       ex_s_i     [4];
   logic [3:0] ex_flags_i [4];
   logic [3:0] flags_o    [4];
   logic       pass_o     [4];
   logic       stall_o    [4];
   logic [2:0] cnt_o      [4];
   logic       err_o      [4];

   int tests  = 0;
   int failed = 0;

   // model state
   logic [3:0] m_flags [4];
   logic       m_pend  [4][4];
   logic       m_err   [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gi
      flag_hazard_ctrl #(
         .DEPTH   (g < 2 ? 1 : 3),
         .FORWARD (g % 2 == 1)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .freeze     (freeze_i[g]),
         .flush      (flush_i[g]),
         .id_valid   (id_valid_i[g]),
         .id_cond    (id_cond_i[g]),
         .id_s       (id_s_i[g]),
         .ex_valid   (ex_valid_i[g]),
         .ex_s       (ex_s_i[g]),
         .ex_flags   (ex_flags_i[g]),
         .flags      (flags_o[g]),
         .cond_pass  (pass_o[g]),
         .cond_stall (stall_o[g]),
         .pend_cnt   (cnt_o[g]),
         .seq_err    (err_o[g])
      );
   end

   function automatic int dep(input int k);
      return (k < 2) ? 1 : 3;
   endfunction

   function automatic bit fwd(input int k);
      return (k % 2) == 1;
   endfunction

   // ARM encoding: base test on cond[3:1], cond[0] inverts it
   function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
      logic nn, zz, cf, vv, base;
      {nn, zz, cf, vv} = f;
      case (cc[3:1])
         3'd0:    base = zz;
         3'd1:    base = cf;
         3'd2:    base = nn;
         3'd3:    base = vv;
         3'd4:    base = cf && !zz;
         3'd5:    base = (nn == vv);
         3'd6:    base = !zz && (nn == vv);
         default: base = 1'b1;
      endcase
      return base ^ cc[0];
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // compare every cycle, then advance the model to the next edge
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         int d, busy, cnt;
         logic exwr, stall, pass, hz, issue;
         logic [3:0] eff;
         d = dep(k);
         if (rst) begin
            m_flags[k] = 4'b0;
            m_err[k]   = 1'b0;
            for (int j = 0; j < 4; j++) m_pend[k][j] = 1'b0;
         end
         exwr = ex_valid_i[k] && ex_s_i[k] && !freeze_i[k];
         eff  = (fwd(k) && exwr) ? ex_flags_i[k] : m_flags[k];
         pass = cond_ok(id_cond_i[k], eff);
         busy = 0;
         cnt  = 0;
         for (int j = 0; j < d; j++) begin
            cnt += int'(m_pend[k][j]);
            if (j < d - 1) busy += int'(m_pend[k][j]);
         end
         hz    = (busy > 0) || (m_pend[k][d-1] && !(fwd(k) && exwr));
         stall = id_valid_i[k] && (id_cond_i[k] < 14) && hz && !flush_i[k];
         issue = id_valid_i[k] && id_s_i[k] && pass && !stall &&
                 !freeze_i[k] && !flush_i[k];
         chk($sformatf("i%0d flags", k), 16'(flags_o[k]), 16'(m_flags[k]));
         chk($sformatf("i%0d pass", k), 16'(pass_o[k]), 16'(pass));
         chk($sformatf("i%0d stall", k), 16'(stall_o[k]), 16'(stall));
         chk($sformatf("i%0d cnt", k), 16'(cnt_o[k]), 16'(cnt));
         chk($sformatf("i%0d err", k), 16'(err_o[k]), 16'(m_err[k]));
         if (!rst) begin
            if (exwr) m_flags[k] = ex_flags_i[k];
            if (!freeze_i[k]) begin
               if ((ex_valid_i[k] && ex_s_i[k]) != m_pend[k][d-1])
                  m_err[k] = 1'b1;
               if (flush_i[k]) begin
                  for (int j = 0; j < 4; j++) m_pend[k][j] = 1'b0;
               end else begin
                  for (int j = d - 1; j > 0; j--) m_pend[k][j] = m_pend[k][j-1];
                  m_pend[k][0] = issue;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      freeze_i[k]   = 1'b0;
      flush_i[k]    = 1'b0;
      id_valid_i[k] = 1'b0;
      id_cond_i[k]  = 4'd14;
      id_s_i[k]     = 1'b0;
      ex_valid_i[k] = 1'b0;
      ex_s_i[k]     = 1'b0;
      ex_flags_i[k] = 4'b0;
   endtask

   initial begin
      logic [15:0] pat;
      pat = 16'h565A;
      for (int k = 0; k < 4; k++) idle(k);

      // reset state
      for (int k = 0; k < 4; k++) begin
         id_valid_i[k] = 1'b1;
         id_cond_i[k]  = 4'd0;
      end
      #3;
      for (int k = 0; k < 4; k++) begin
         chk("rst flags", 16'(flags_o[k]), 16'h0);
         chk("rst eq", 16'(pass_o[k]), 16'h0);
         chk("rst stall", 16'(stall_o[k]), 16'h0);
         chk("rst cnt", 16'(cnt_o[k]), 16'h0);
         id_cond_i[k] = 4'd1;
      end
      #1;
      for (int k = 0; k < 4; k++) chk("rst ne", 16'(pass_o[k]), 16'h1);
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) idle(k);

      // DEPTH=1: SUBS then BEQ, without (i0) and with (i1) forwarding
      cyc();
      for (int k = 0; k < 2; k++) begin
         id_valid_i[k] = 1'b1;
         id_s_i[k]     = 1'b1;
         id_cond_i[k]  = 4'd14;
      end
      cyc();
      for (int k = 0; k < 2; k++) begin
         id_s_i[k]     = 1'b0;
         id_cond_i[k]  = 4'd0;
         ex_valid_i[k] = 1'b1;
         ex_s_i[k]     = 1'b1;
         ex_flags_i[k] = 4'b0100;
      end
      #2;
      chk("d1 nofwd stall", 16'(stall_o[0]), 16'h1);
      chk("d1 fwd stall", 16'(stall_o[1]), 16'h0);
      chk("d1 fwd pass", 16'(pass_o[1]), 16'h1);
      cyc();
      for (int k = 0; k < 2; k++) begin
         ex_valid_i[k] = 1'b0;
         ex_s_i[k]     = 1'b0;
      end
      #2;
      chk("d1 flags", 16'(flags_o[0]), 16'h4);
      chk("d1 pass", 16'(pass_o[0]), 16'h1);
      chk("d1 stall", 16'(stall_o[0]), 16'h0);
      chk("d1 err", 16'(err_o[0]), 16'h0);
      cyc();
      idle(0);
      idle(1);

      // DEPTH=3: ADDS then flush
      id_valid_i[2] = 1'b1;
      id_s_i[2]     = 1'b1;
      cyc();
      id_valid_i[2] = 1'b0;
      id_s_i[2]     = 1'b0;
      flush_i[2]    = 1'b1;
      #2;
      chk("flush cnt1", 16'(cnt_o[2]), 16'h1);
      cyc();
      flush_i[2]    = 1'b0;
      id_valid_i[2] = 1'b1;
      id_cond_i[2]  = 4'd0;
      #2;
      chk("flush cnt0", 16'(cnt_o[2]), 16'h0);
      chk("flush stall", 16'(stall_o[2]), 16'h0);
      chk("flush err", 16'(err_o[2]), 16'h0);
      cyc();
      idle(2);

      // DEPTH=3: freeze with pend=010, then release
      id_valid_i[3] = 1'b1;
      id_s_i[3]     = 1'b1;
      cyc();
      idle(3);
      cyc();
      for (int i = 0; i < 3; i++) begin
         if (i > 0) cyc();
         freeze_i[3]   = 1'b1;
         ex_valid_i[3] = 1'b1;
         ex_s_i[3]     = 1'b1;
         ex_flags_i[3] = 4'b1111;
         #2;
         chk("frz cnt", 16'(cnt_o[3]), 16'h1);
         chk("frz flags", 16'(flags_o[3]), 16'h0);
         chk("frz err", 16'(err_o[3]), 16'h0);
      end
      cyc();
      idle(3);
      #2;
      chk("rel cnt", 16'(cnt_o[3]), 16'h1);
      chk("rel flags", 16'(flags_o[3]), 16'h0);
      cyc();
      ex_valid_i[3] = 1'b1;
      ex_s_i[3]     = 1'b1;
      ex_flags_i[3] = 4'b0011;
      cyc();
      idle(3);
      #2;
      chk("rel cnt0", 16'(cnt_o[3]), 16'h0);
      chk("rel err", 16'(err_o[3]), 16'h0);
      chk("rel flags2", 16'(flags_o[3]), 16'h3);

      // unexpected EX writer sets seq_err; then condition sweep
      cyc();
      ex_valid_i[0] = 1'b1;
      ex_s_i[0]     = 1'b1;
      ex_flags_i[0] = 4'b1001;
      #2;
      chk("err pre", 16'(err_o[0]), 16'h0);
      cyc();
      idle(0);
      #2;
      chk("err set", 16'(err_o[0]), 16'h1);
      chk("err flags", 16'(flags_o[0]), 16'h9);
      for (int c = 0; c < 16; c++) begin
         cyc();
         id_valid_i[0] = 1'b1;
         id_cond_i[0]  = 4'(c);
         #2;
         chk($sformatf("sweep c%0d", c), 16'(pass_o[0]), 16'(pat[c]));
      end
      chk("err sticky", 16'(err_o[0]), 16'h1);
      cyc();
      idle(0);
      rst = 1'b1;
      #2;
      chk("err clr", 16'(err_o[0]), 16'h0);
      chk("rst flags2", 16'(flags_o[0]), 16'h0);
      cyc();
      rst = 1'b0;

      // randomized traffic, EX writers follow the model's EX slot
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (n == 1500) rst = 1'b1;
         if (n == 1502) rst = 1'b0;
         for (int k = 0; k < 4; k++) begin
            logic top;
            top = m_pend[k][dep(k)-1];
            freeze_i[k]   = ($urandom_range(9) == 0);
            flush_i[k]    = ($urandom_range(11) == 0);
            id_valid_i[k] = ($urandom_range(4) != 0);
            id_cond_i[k]  = 4'($urandom_range(15));
            id_s_i[k]     = 1'($urandom_range(1));
            ex_flags_i[k] = 4'($urandom_range(15));
            ex_valid_i[k] = top ? 1'b1 : 1'($urandom_range(1));
            ex_s_i[k]     = top;
            if ($urandom_range(299) == 0) begin
               ex_valid_i[k] = 1'b1;
               ex_s_i[k]     = ~top;
            end
         end
      end
      cyc();
      for (int k = 0; k < 4; k++) idle(k);
      cyc();
      cyc();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
